// File: rtl/rom_seq_pkg.sv
// Shared definitions for the ROM address sequencer: default address width,
// step-direction encoding and constant helpers used to size counters.
package rom_seq_pkg;

    // Address width of rom_module on this board.
    localparam int ADDR_W_DEF = 3;

    // Direction switch encoding as seen after synchronization.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Auto-step prescaler period in clock cycles. Returns 0 for nonsensical
    // rates so the caller's elaboration check rejects them together with
    // any period shorter than two cycles.
    function automatic int calc_div(input int clk_hz, input int step_hz);
        if (clk_hz <= 0 || step_hz <= 0) begin
            return 0;
        end
        return clk_hz / step_hz;
    endfunction

    // Bits needed for a counter that runs 0..count-1, never less than 1.
    function automatic int clog2_min1(input int count);
        for (int w = 1; w < 31; w++) begin
            if ((1 << w) >= count) begin
                return w;
            end
        end
        return 31;
    endfunction

endpackage

// File: rtl/rom_addr_sequencer_button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stable-time debouncer and a
// one-cycle pulse on each accepted press (release produces nothing).
module button_debouncer
    import rom_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_check
        $error("button_debouncer: DEBOUNCE_CYCLES must be at least 1");
    end

    logic             sync_q1;
    logic             sync_q2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the two synchronizer stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_q2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync_q2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // One-cycle delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // A press is the first cycle the debounced level is seen high.
    assign rise_pulse = level & ~level_d;

endmodule

// File: rtl/rom_addr_sequencer.sv
// ROM address sequencer: steps a wrapping address on a debounced button press
// or on an auto-step tick, in the direction chosen by the dir switch.
module rom_addr_sequencer
    import rom_seq_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int STEP_HZ         = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ADDR_W          = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_step,
    input  logic              auto_en,
    input  logic              dir,
    output logic [ADDR_W-1:0] addr,
    output logic              step_pulse
);

    localparam int DIV   = calc_div(CLK_HZ, STEP_HZ);
    localparam int PRE_W = clog2_min1(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("rom_addr_sequencer: CLK_HZ/STEP_HZ must be at least 2");
    end

    if (ADDR_W < 1) begin : g_addr_check
        $error("rom_addr_sequencer: ADDR_W must be at least 1");
    end

    logic              press;
    logic              unused_btn_level;
    logic [1:0]        auto_sync;
    logic [1:0]        dir_sync;
    logic              auto_s;
    dir_e              step_dir;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic              step_evt;
    logic [ADDR_W-1:0] addr_next;

    // The debounced level itself is not needed here; stepping uses the press pulse.
    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_debouncer (
        .clk        (clk),
        .rst        (rst),
        .raw        (btn_step),
        .level      (unused_btn_level),
        .rise_pulse (press)
    );

    // Two-flop synchronizers for the mode and direction switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_sync <= 2'b00;
            dir_sync  <= 2'b00;
        end else begin
            auto_sync <= {auto_sync[0], auto_en};
            dir_sync  <= {dir_sync[0], dir};
        end
    end

    assign auto_s   = auto_sync[1];
    assign step_dir = dir_e'(dir_sync[1]);

    // Auto-step prescaler: cycles 0..DIV-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (!auto_s || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign tick = auto_s && (pre_cnt == PRE_LAST);

    // A coincident press and tick merge into a single step.
    assign step_evt = press | tick;

    // Next address: one step up or down, wrapping naturally at both ends.
    // NOTE: addr_next is given its hold value before any branch so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        addr_next = addr;
        if (step_evt) begin
            case (step_dir)
                DIR_UP:   addr_next = addr + ADDR_W'(1);
                DIR_DOWN: addr_next = addr - ADDR_W'(1);
                default:  addr_next = addr;
            endcase
        end
    end

    // Address register and the matching one-cycle step indicator.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            step_pulse <= 1'b0;
        end else begin
            addr       <= addr_next;
            step_pulse <= step_evt;
        end
    end

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// Self-checking bench for rom_addr_sequencer with CLK_HZ=8, STEP_HZ=1
// (DIV=8) and DEBOUNCE_CYCLES=4. A reference model built from sampled input
// history predicts every step; a monitor pops and compares each step_pulse.
module tb_rom_addr_sequencer;

    localparam int CLK_HZ  = 8;
    localparam int STEP_HZ = 1;
    localparam int DC      = 4;
    localparam int AW      = 3;
    localparam int DIV     = CLK_HZ / STEP_HZ;
    localparam int AMOD    = 1 << AW;
    localparam int MAXE    = 4096;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          btn_step = 1'b0;
    logic          auto_en  = 1'b0;
    logic          dir      = 1'b0;
    logic [AW-1:0] addr;
    logic          step_pulse;

    rom_addr_sequencer #(
        .CLK_HZ          (CLK_HZ),
        .STEP_HZ         (STEP_HZ),
        .DEBOUNCE_CYCLES (DC),
        .ADDR_W          (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .auto_en    (auto_en),
        .dir        (dir),
        .addr       (addr),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Input history indexed by edge number; edge 0 is the first rising edge.
    bit rst_h  [MAXE];
    bit btn_h  [MAXE];
    bit auto_h [MAXE];
    bit dir_h  [MAXE];

    int edge_n     = 0;
    int m_addr     = 0;
    bit m_level    = 1'b0;
    int m_bound    = 0;     // last edge where the debounced level flipped or reset hit
    int m_rise_at  = -10;   // edge at which the debounced level last went high
    int m_last_rst = 0;
    int exp_q[$];
    int pulse_cnt  = 0;

    // Logic sees each switch as it was sampled two edges earlier, or 0 if a
    // reset landed on either of the two intervening edges.
    function automatic bit sync_of(input int sel, input int n);
        if (n < 2) return 1'b0;
        if (rst_h[n-1] || rst_h[n-2]) return 1'b0;
        case (sel)
            0:       return btn_h[n-2];
            1:       return auto_h[n-2];
            default: return dir_h[n-2];
        endcase
    endfunction

    task automatic model_edge();
        int  n;
        int  run;
        bit  press;
        bit  tick;
        bit  flip;
        n = edge_n;
        if (n >= MAXE) begin
            $display("FAIL edge_budget: got %0d edges, limit %0d", n, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        rst_h[n]  = rst;
        btn_h[n]  = btn_step;
        auto_h[n] = auto_en;
        dir_h[n]  = dir;
        if (rst) begin
            m_addr     = 0;
            m_level    = 1'b0;
            m_bound    = n;
            m_last_rst = n;
            m_rise_at  = -10;
        end else begin
            // A press steps the edge right after the debounced level rose.
            press = (m_rise_at == n - 1);
            // A tick lands whenever the unbroken enabled run is a multiple of DIV.
            run = 0;
            for (int k = n; k > m_last_rst && sync_of(1, k); k--) run++;
            tick = (run > 0) && (run % DIV == 0);
            // The level flips once DC consecutive samples since the last flip disagree.
            flip = (n - m_bound >= DC);
            for (int k = n - DC + 1; k <= n; k++) begin
                if (flip && sync_of(0, k) == m_level) flip = 1'b0;
            end
            if (flip) begin
                m_level = !m_level;
                m_bound = n;
                if (m_level) m_rise_at = n;
            end
            if (press || tick) begin
                m_addr = sync_of(2, n) ? (m_addr + AMOD - 1) % AMOD : (m_addr + 1) % AMOD;
                exp_q.push_back(m_addr);
            end
        end
        edge_n = n + 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic monitor_cycle();
        if (step_pulse === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) check("unexpected_step", step_pulse, 0);
            else                   check("step_addr", addr, exp_q.pop_front());
        end
        check("pending_step", exp_q.size(), 0);
        if (exp_q.size() != 0) exp_q.delete();
        check("addr_track", addr, m_addr);
    endtask

    initial forever begin
        @(negedge clk);
        monitor_cycle();
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_pulse(input int budget, output int at_edge);
        at_edge = -1000;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) begin
                at_edge = edge_n;
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    task automatic press_once();
        btn_step = 1'b1;
        idle(10);
        btn_step = 1'b0;
        idle(10);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int e;
        int base;
        int p0;

        // 1. Reset with random inputs, then quiet idle.
        for (int i = 0; i < 3; i++) begin
            btn_step = 1'($urandom_range(0, 1));
            auto_en  = 1'($urandom_range(0, 1));
            dir      = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_addr", addr, 0);
            check("rst_pulse", step_pulse, 0);
        end
        rst = 1'b0; btn_step = 1'b0; auto_en = 1'b0; dir = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_addr", addr, 0);
            check("idle_pulse", step_pulse, 0);
        end

        // 2. Manual step: exact latency, single step per hold, wrap.
        base = edge_n;
        btn_step = 1'b1;
        wait_pulse(20, e);
        check("t2_first_step_edge", e - base, 7);
        check("t2_first_addr", addr, 1);
        idle(13);
        btn_step = 1'b0;
        idle(10);
        check("t2_hold_one_step", addr, 1);
        press_once();
        press_once();
        check("t2_two_presses", addr, 3);
        p0 = pulse_cnt;
        for (int i = 0; i < 8; i++) press_once();
        check("t2_wrap_addr", addr, 3);
        check("t2_wrap_pulses", pulse_cnt - p0, 8);

        // 3. Glitches of 1..3 cycles are ignored.
        p0 = pulse_cnt;
        for (int w = 1; w <= 3; w++) begin
            btn_step = 1'b1;
            idle(w);
            btn_step = 1'b0;
            idle(10);
        end
        check("t3_addr", addr, 3);
        check("t3_pulses", pulse_cnt - p0, 0);

        // 4. Auto mode counting down from 0.
        do_reset(2);
        dir = 1'b1;
        idle(4);
        base = edge_n;
        auto_en = 1'b1;
        wait_pulse(30, e);
        check("t4_step1_edge", e - base, 10);
        check("t4_step1_addr", addr, 7);
        @(negedge clk);
        check("t4_step1_width", step_pulse, 0);
        wait_pulse(30, e);
        check("t4_step2_edge", e - base, 18);
        check("t4_step2_addr", addr, 6);
        @(negedge clk);
        check("t4_step2_width", step_pulse, 0);
        wait_pulse(30, e);
        check("t4_step3_edge", e - base, 26);
        check("t4_step3_addr", addr, 5);
        @(negedge clk);
        check("t4_step3_width", step_pulse, 0);
        auto_en = 1'b0; dir = 1'b0;
        idle(12);

        // 5. Press and tick on the same edge give one step.
        do_reset(2);
        idle(4);
        base = edge_n;
        auto_en = 1'b1;
        idle(3);
        btn_step = 1'b1;
        wait_pulse(30, e);
        check("t5_merged_edge", e - base, 10);
        check("t5_merged_addr", addr, 1);
        wait_pulse(30, e);
        check("t5_next_edge", e - base, 18);
        check("t5_next_addr", addr, 2);
        btn_step = 1'b0; auto_en = 1'b0;
        idle(12);

        // 6. Reset mid-operation discards the pending tick.
        do_reset(2);
        idle(4);
        base = edge_n;
        auto_en = 1'b1;
        for (int i = 0; i < 5; i++) wait_pulse(30, e);
        check("t6_fifth_edge", e - base, 42);
        check("t6_fifth_addr", addr, 5);
        idle(6);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_addr", addr, 0);
        check("t6_rst_pulse", step_pulse, 0);
        rst = 1'b0;
        base = edge_n;
        wait_pulse(30, e);
        check("t6_restart_edge", e - base, 10);
        check("t6_restart_addr", addr, 1);
        auto_en = 1'b0;
        idle(12);

        // 7. Random mixed traffic checked by the model.
        for (int seg = 0; seg < 150; seg++) begin
            btn_step = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 2) == 0) dir = ~dir;
            rst = ($urandom_range(0, 40) == 0);
            idle($urandom_range(1, 12));
            rst = 1'b0;
        end
        btn_step = 1'b0; auto_en = 1'b0; dir = 1'b0;
        idle(20);

        check("end_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
